ext_bus_arb: RTL and testbench
==============================

# ext_bus_arb

Parametrised external-bus controller and arbiter; the successor to the fixed two-port memory synchroniser. It arbitrates up to NCH internal requesters (prefetch, execute, future DMA/UART) onto the single multiplexed address/data pin bus. Arbitration is fixed-priority or round-robin. Each bus cycle has a programmable number of wait states and an I/O-space select. It sits between the CPU pipeline stages and the physical pins at the top level.

## Interface
- NCH, 2: number of requester channels (1..8)
- AW, 20: address width; must be greater than DW
- DW, 16: data width, also the width of the multiplexed pin bus
- WAIT, 1: extra strobe cycles per data phase (0..15)
- RR, 1: arbitration mode; 0 = fixed (lowest index wins), 1 = round-robin
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NCH  per-channel request, level
- rw  in  NCH  per-channel direction; 1 = write
- io  in  NCH  per-channel I/O-space select
- adr  in  NCH*AW  per-channel address; channel i occupies bits [i*AW +: AW]
- dtw  in  NCH*DW  per-channel write data, same packing as adr
- ack  out  NCH  one-cycle completion pulse, one-hot
- dtr  out  DW  read data; valid in the ack cycle and held until the next read completes
- busy  out  1  high while the FSM is not IDLE
- din  in  DW  pin bus input
- dout  out  DW  pin bus output value
- isout  out  1  pin bus output enable
- adr_hi  out  AW-DW  upper address lines
- ale_n, oe_n, we_n  out  1 each  address latch enable, read strobe, write strobe; all active-low
- pio  out  1  I/O-space cycle flag

## Operation
- FSM states: IDLE, ADDR, HOLD, DATA, DONE. Encoding is binary, defined in the package.
- **IDLE**
  - If any req bit is high, register the grant, latch that channel's adr/rw/io/dtw, and go to ADDR.
  - If no req bit is high, stay in IDLE.
- **ADDR:** isout=1, dout=adr[DW-1:0], adr_hi=adr[AW-1:DW], pio=io, ale_n=0.
- **HOLD:** ale_n=1; the external latch closes on this rising edge. The address stays driven.
  - On a read, isout=0 in this state (bus turnaround).
  - On a write, dout=dtw.
- **DATA:** lasts WAIT+1 cycles, counted by a wait counter.
  - Read: oe_n=0; din is captured into dtr on the last DATA cycle.
  - Write: we_n=0, isout=1, dout=dtw.
- **DONE:** all strobes deasserted, isout=0, ack[grant]=1 for exactly one cycle, then return to IDLE.
- adr_hi and pio hold their values from ADDR through DONE, and return to 0 in IDLE.
- **Fixed arbitration (RR=0):** the lowest-index requesting channel wins.
- **Round-robin arbitration (RR=1):** the winner is the first requesting channel strictly after last_grant, wrapping from NCH-1 to 0. last_grant updates when a grant is taken.
- Requesters must hold adr/rw/io/dtw stable until ack, and must drop req in the cycle after ack unless they want another transfer.
- req deasserting mid-transaction is ignored; the cycle completes.
- A channel's new req becomes visible only in IDLE. Consequences:
  - Back-to-back transfers from one channel have one IDLE gap between them.
  - Under RR, other pending channels are served before that channel repeats.

## Timing
- All outputs come from registers; no combinational path from req to the pins.
- Reset values: ack=0, dtr=0, busy=0, dout=0, isout=0, adr_hi=0, pio=0, ale_n=1, oe_n=1, we_n=1, state=IDLE, last_grant=NCH-1 (so channel 0 is first under RR).
- Latency: if req is sampled high in IDLE at cycle 0, ack is high in cycle WAIT+4. A full transaction including the IDLE cycle takes WAIT+5 cycles.
- Asserting reset mid-transaction immediately forces every output to its reset value. Requester handshake state is not preserved.
- oe_n and we_n are never low in the same cycle. isout is never 1 while oe_n is 0.
- Width rules:
  - The wait counter is $clog2(WAIT+1) bits, minimum 1.
  - Grant index is $clog2(NCH) bits, minimum 1.

## Structure
- Package ext_bus_pkg holds:
  - state enumeration
  - ARB_FIXED/ARB_RR constants
  - a function computing counter widths
- Sub-module rr_pick (parameter NCH), purely combinational: inputs req, last_grant, mode; outputs grant index and valid.
- The top-level CPU replaces its two-port synchroniser with ext_bus_arb at NCH=2, mapping active-low strobes to pins directly.

## Test plan
- Single read, WAIT=1, channel 0, adr=0x5A3C4, din=0xBEEF during DATA:
  - ale_n low at cycle 1 with dout=0xA3C4 and adr_hi=0x5.
  - oe_n low for cycles 3-4.
  - ack[0] at cycle 5 with dtr=0xBEEF.
- Single write, WAIT=0, channel 1, io=1, dtw=0x1234: we_n low for 1 cycle with dout=0x1234 and pio=1; ack[1] at cycle 4; oe_n never low.
- RR=1, NCH=3, all req held high for 6 transfers: grant order 0,1,2,0,1,2.
- RR=0, same stimulus: channel 0 is served on every transfer.
- Reset asserted during DATA of a write: we_n=1, isout=0, ack=0 in the same cycle. After release, a new request to channel 0 completes normally.
- WAIT=15 read: oe_n low for exactly 16 cycles; dtr unchanged until the ack cycle.

Source files
------------

// File: rtl/ext_bus_pkg.sv
// Shared types and helpers for the external bus controller/arbiter.
// Holds the FSM encoding, arbitration modes and counter width helper.
package ext_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_HOLD = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    // Bits needed to count n distinct values, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ext_bus_arb_rr_pick.sv
// Combinational requester picker for the external bus arbiter.
// Fixed mode picks the lowest index; round-robin starts after last_grant.
module rr_pick
    import ext_bus_pkg::*;
#(
    parameter int NCH = 2,
    parameter int GW  = cnt_w(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [GW-1:0]  last_grant,
    input  logic           mode,
    output logic [GW-1:0]  grant,
    output logic           valid
);

    logic [2*NCH-1:0] dbl;
    logic [NCH-1:0]   rot;
    int               sh;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        sh    = int'(last_grant) + 1;
        dbl   = {req, req};
        // rot[j] is channel (last_grant + 1 + j) mod NCH
        rot   = NCH'(dbl >> sh);
        if (mode == ARB_RR) begin
            for (int j = NCH - 1; j >= 0; j--) begin
                if (|(rot & (NCH'(1) << j))) begin
                    grant = GW'((sh + j) % NCH);
                    valid = 1'b1;
                end
            end
        end else begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (|(req & (NCH'(1) << i))) begin
                    grant = GW'(i);
                    valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ext_bus_arb.sv
// Multi-channel external bus controller with fixed or round-robin arbitration.
// Drives the multiplexed address/data pin bus with registered outputs only.
module ext_bus_arb
    import ext_bus_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int AW   = 20,
    parameter int DW   = 16,
    parameter int WAIT = 1,
    parameter int RR   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    rw,
    input  logic [NCH-1:0]    io,
    input  logic [NCH*AW-1:0] adr,
    input  logic [NCH*DW-1:0] dtw,
    output logic [NCH-1:0]    ack,
    output logic [DW-1:0]     dtr,
    output logic              busy,
    input  logic [DW-1:0]     din,
    output logic [DW-1:0]     dout,
    output logic              isout,
    output logic [AW-DW-1:0]  adr_hi,
    output logic              ale_n,
    output logic              oe_n,
    output logic              we_n,
    output logic              pio
);

    localparam int GW = cnt_w(NCH);
    localparam int CW = cnt_w(WAIT + 1);
    localparam int HW = AW - DW;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT);
    localparam logic MODE = (RR == 0) ? ARB_FIXED : ARB_RR;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic            rw_q, rw_d;
    logic            io_q, io_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dtw_q, dtw_d;

    logic [NCH-1:0]  ack_q, ack_d;
    logic [DW-1:0]   dtr_q, dtr_d;
    logic            busy_q, busy_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic            isout_q, isout_d;
    logic [HW-1:0]   adr_hi_q, adr_hi_d;
    logic            ale_n_q, ale_n_d;
    logic            oe_n_q, oe_n_d;
    logic            we_n_q, we_n_d;
    logic            pio_q, pio_d;

    logic [GW-1:0]   pick;
    logic            pick_vld;
    logic [NCH-1:0]  sel;

    rr_pick #(
        .NCH (NCH),
        .GW  (GW)
    ) u_pick (
        .req        (req),
        .last_grant (last_q),
        .mode       (MODE),
        .grant      (pick),
        .valid      (pick_vld)
    );

    assign sel = NCH'(1) << pick;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        last_d  = last_q;
        rw_d    = rw_q;
        io_d    = io_q;
        adr_d   = adr_q;
        dtw_d   = dtw_q;
        dtr_d   = dtr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_ADDR;
                    grant_d = pick;
                    last_d  = pick;
                    rw_d    = |(rw & sel);
                    io_d    = |(io & sel);
                    adr_d   = AW'(adr >> (int'(pick) * AW));
                    dtw_d   = DW'(dtw >> (int'(pick) * DW));
                end
            end
            ST_ADDR: state_d = ST_HOLD;
            ST_HOLD: begin
                state_d = ST_DATA;
                cnt_d   = '0;
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    if (!rw_q) begin
                        dtr_d = din;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Pin values are derived from the next state so they register with it.
    always_comb begin
        ack_d    = '0;
        busy_d   = (state_d != ST_IDLE);
        dout_d   = '0;
        isout_d  = 1'b0;
        adr_hi_d = '0;
        ale_n_d  = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        pio_d    = 1'b0;
        unique case (state_d)
            ST_IDLE: ;
            ST_ADDR: begin
                isout_d  = 1'b1;
                dout_d   = adr_d[DW-1:0];
                adr_hi_d = adr_d[AW-1:DW];
                pio_d    = io_d;
                ale_n_d  = 1'b0;
            end
            ST_HOLD: begin
                adr_hi_d = adr_d[AW-1:DW];
                pio_d    = io_d;
                if (rw_d) begin
                    isout_d = 1'b1;
                    dout_d  = dtw_d;
                end else begin
                    dout_d  = adr_d[DW-1:0];
                end
            end
            ST_DATA: begin
                adr_hi_d = adr_d[AW-1:DW];
                pio_d    = io_d;
                if (rw_d) begin
                    we_n_d  = 1'b0;
                    isout_d = 1'b1;
                    dout_d  = dtw_d;
                end else begin
                    oe_n_d  = 1'b0;
                end
            end
            ST_DONE: begin
                adr_hi_d = adr_d[AW-1:DW];
                pio_d    = io_d;
                ack_d    = NCH'(1) << grant_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            grant_q  <= '0;
            last_q   <= GW'(NCH - 1);
            rw_q     <= 1'b0;
            io_q     <= 1'b0;
            adr_q    <= '0;
            dtw_q    <= '0;
            ack_q    <= '0;
            dtr_q    <= '0;
            busy_q   <= 1'b0;
            dout_q   <= '0;
            isout_q  <= 1'b0;
            adr_hi_q <= '0;
            ale_n_q  <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            pio_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            rw_q     <= rw_d;
            io_q     <= io_d;
            adr_q    <= adr_d;
            dtw_q    <= dtw_d;
            ack_q    <= ack_d;
            dtr_q    <= dtr_d;
            busy_q   <= busy_d;
            dout_q   <= dout_d;
            isout_q  <= isout_d;
            adr_hi_q <= adr_hi_d;
            ale_n_q  <= ale_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            pio_q    <= pio_d;
        end
    end

    assign ack    = ack_q;
    assign dtr    = dtr_q;
    assign busy   = busy_q;
    assign dout   = dout_q;
    assign isout  = isout_q;
    assign adr_hi = adr_hi_q;
    assign ale_n  = ale_n_q;
    assign oe_n   = oe_n_q;
    assign we_n   = we_n_q;
    assign pio    = pio_q;

endmodule

// File: tb/tb_ext_bus_arb.sv
// Scoreboard bench for ext_bus_arb: three instances with different
// wait-state and arbitration settings share one set of requester buses.
module tb_ext_bus_arb;

    localparam int P_ACK = 0, P_DTR = 1, P_BUSY = 2, P_DOUT = 3;
    localparam int P_ISOUT = 4, P_ADRHI = 5, P_ALE = 6, P_OE = 7;
    localparam int P_WE = 8, P_PIO = 9;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req_a, req_b, req_c;
    logic [2:0]  rw, io;
    logic [59:0] adr;
    logic [47:0] dtw;
    logic [15:0] din;

    logic [2:0]  ack_a, ack_b, ack_c;
    logic [15:0] dtr_a, dtr_b, dtr_c;
    logic [15:0] dout_a, dout_b, dout_c;
    logic [3:0]  ahi_a, ahi_b, ahi_c;
    logic        busy_a, busy_b, busy_c;
    logic        isout_a, isout_b, isout_c;
    logic        ale_a, ale_b, ale_c;
    logic        oe_a, oe_b, oe_c;
    logic        we_a, we_b, we_c;
    logic        pio_a, pio_b, pio_c;

    logic [44:0] ob_a, ob_b, ob_c;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ext_bus_arb #(.NCH(3), .AW(20), .DW(16), .WAIT(1), .RR(1)) u_a (
        .clk(clk), .reset(reset), .req(req_a), .rw(rw), .io(io),
        .adr(adr), .dtw(dtw), .ack(ack_a), .dtr(dtr_a),
        .busy(busy_a), .din(din), .dout(dout_a), .isout(isout_a),
        .adr_hi(ahi_a), .ale_n(ale_a), .oe_n(oe_a), .we_n(we_a),
        .pio(pio_a));

    ext_bus_arb #(.NCH(3), .AW(20), .DW(16), .WAIT(0), .RR(0)) u_b (
        .clk(clk), .reset(reset), .req(req_b), .rw(rw), .io(io),
        .adr(adr), .dtw(dtw), .ack(ack_b), .dtr(dtr_b),
        .busy(busy_b), .din(din), .dout(dout_b), .isout(isout_b),
        .adr_hi(ahi_b), .ale_n(ale_b), .oe_n(oe_b), .we_n(we_b),
        .pio(pio_b));

    ext_bus_arb #(.NCH(3), .AW(20), .DW(16), .WAIT(15), .RR(1)) u_c (
        .clk(clk), .reset(reset), .req(req_c), .rw(rw), .io(io),
        .adr(adr), .dtw(dtw), .ack(ack_c), .dtr(dtr_c),
        .busy(busy_c), .din(din), .dout(dout_c), .isout(isout_c),
        .adr_hi(ahi_c), .ale_n(ale_c), .oe_n(oe_c), .we_n(we_c),
        .pio(pio_c));

    assign ob_a = {ack_a, dtr_a, busy_a, dout_a, isout_a,
                   ahi_a, ale_a, oe_a, we_a, pio_a};
    assign ob_b = {ack_b, dtr_b, busy_b, dout_b, isout_b,
                   ahi_b, ale_b, oe_b, we_b, pio_b};
    assign ob_c = {ack_c, dtr_c, busy_c, dout_c, isout_c,
                   ahi_c, ale_c, oe_c, we_c, pio_c};

    function automatic logic [31:0] pin(input int k, input int s);
        logic [44:0] v;
        case (k)
            0:       v = ob_a;
            1:       v = ob_b;
            default: v = ob_c;
        endcase
        case (s)
            P_ACK:   return 32'(v[44:42]);
            P_DTR:   return 32'(v[41:26]);
            P_BUSY:  return 32'(v[25]);
            P_DOUT:  return 32'(v[24:9]);
            P_ISOUT: return 32'(v[8]);
            P_ADRHI: return 32'(v[7:4]);
            P_ALE:   return 32'(v[3]);
            P_OE:    return 32'(v[2]);
            P_WE:    return 32'(v[1]);
            default: return 32'(v[0]);
        endcase
    endfunction

    typedef struct {
        int          cyc;
        int          inst;
        int          sig;
        logic [31:0] val;
        string       nm;
    } pexp_t;

    typedef struct {
        int          inst;
        int          cyc;
        int          ch;
        logic [15:0] dtr;
    } aexp_t;

    pexp_t pq[$];
    aexp_t aq[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit done = 1'b0;
    bit fin  = 1'b0;

    task automatic pe(input int c, input int k, input int s,
                      input logic [31:0] v, input string nm);
        pexp_t e;
        e.cyc = c; e.inst = k; e.sig = s; e.val = v; e.nm = nm;
        pq.push_back(e);
    endtask

    task automatic ae(input int k, input int c, input int ch,
                      input logic [15:0] d);
        aexp_t e;
        e.inst = k; e.cyc = c; e.ch = ch; e.dtr = d;
        aq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h want %0h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic at(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops ack expectations, checks pin expectations and invariants.
    always @(negedge clk) begin
        if (!fin) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("oe_we_excl%0d", k),
                    pin(k, P_OE) | pin(k, P_WE), 32'd1);
                chk($sformatf("isout_oe%0d", k),
                    pin(k, P_ISOUT) & ~pin(k, P_OE), 32'd0);
                if (pin(k, P_ACK) != 0) begin
                    int found;
                    found = -1;
                    for (int i = 0; i < aq.size(); i++)
                        if (found < 0 && aq[i].inst == k) found = i;
                    if (found < 0) begin
                        chk($sformatf("unexp_ack%0d", k), pin(k, P_ACK), 0);
                    end else begin
                        aexp_t e;
                        e = aq[found];
                        aq.delete(found);
                        chk($sformatf("ack_ch%0d", k), pin(k, P_ACK),
                            32'd1 << e.ch);
                        chk($sformatf("ack_cyc%0d", k), cyc, e.cyc);
                        chk($sformatf("ack_dtr%0d", k), pin(k, P_DTR),
                            32'(e.dtr));
                    end
                end
            end
            for (int i = aq.size() - 1; i >= 0; i--) begin
                if (aq[i].cyc < cyc) begin
                    chk($sformatf("missing_ack%0d", aq[i].inst), cyc,
                        aq[i].cyc);
                    aq.delete(i);
                end
            end
            for (int i = pq.size() - 1; i >= 0; i--) begin
                if (pq[i].cyc <= cyc) begin
                    chk($sformatf("%s%0d", pq[i].nm, pq[i].inst),
                        (pq[i].cyc == cyc) ? pin(pq[i].inst, pq[i].sig)
                                           : 32'hDEAD_0000,
                        pq[i].val);
                    pq.delete(i);
                end
            end
            if (done || cyc > 4000) begin
                if (!done) chk("timeout", cyc, 4000);
                chk("leftover_acks", aq.size(), 0);
                chk("leftover_pins", pq.size(), 0);
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                fin = 1'b1;
                $finish;
            end
        end
    end

    initial begin
        int c0, c1;
        int rv[10];
        rv = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
        req_a = '0; req_b = '0; req_c = '0;
        rw = '0; io = '0; adr = '0; dtw = '0; din = '0;
        for (int k = 0; k < 3; k++)
            for (int s = 0; s < 10; s++)
                pe(4, k, s, 32'(rv[s]), $sformatf("rst_s%0d_", s));
        at(3);
        reset = 1'b0;

        // Round-robin: all channels held high, six reads
        adr = {20'h30003, 20'h20002, 20'h10001};
        din = 16'h7777;
        at(6);
        c0 = cyc;
        req_a = 3'b111;
        for (int t = 0; t < 6; t++) begin
            ae(0, c0 + 5 + 6 * t, t % 3, 16'h7777);
            pe(c0 + 1 + 6 * t, 0, P_DOUT, 32'(t % 3 + 1), "rr_dout");
            pe(c0 + 1 + 6 * t, 0, P_ADRHI, 32'(t % 3 + 1), "rr_ahi");
        end
        at(c0 + 36);
        req_a = '0;

        // Single read, WAIT=1
        at(c0 + 40);
        c0 = cyc;
        adr[19:0] = 20'h5A3C4;
        din = 16'hBEEF;
        req_a = 3'b001;
        pe(c0 + 1, 0, P_ALE, 0, "rd_ale");
        pe(c0 + 1, 0, P_DOUT, 32'hA3C4, "rd_dout");
        pe(c0 + 1, 0, P_ADRHI, 32'h5, "rd_ahi");
        pe(c0 + 1, 0, P_ISOUT, 1, "rd_isout_a");
        pe(c0 + 1, 0, P_BUSY, 1, "rd_busy");
        pe(c0 + 2, 0, P_ISOUT, 0, "rd_turn");
        pe(c0 + 2, 0, P_OE, 1, "rd_oe_pre");
        pe(c0 + 3, 0, P_OE, 0, "rd_oe3");
        pe(c0 + 4, 0, P_OE, 0, "rd_oe4");
        pe(c0 + 5, 0, P_OE, 1, "rd_oe_post");
        pe(c0 + 5, 0, P_ADRHI, 32'h5, "rd_ahi_done");
        pe(c0 + 6, 0, P_ADRHI, 0, "rd_ahi_idle");
        ae(0, c0 + 5, 0, 16'hBEEF);
        at(c0 + 6);
        req_a = '0;

        // Single I/O write on channel 1, WAIT=0
        at(cyc + 3);
        c0 = cyc;
        adr[39:20] = 20'h2ABCD;
        dtw[31:16] = 16'h1234;
        rw = 3'b010;
        io = 3'b010;
        req_b = 3'b010;
        pe(c0 + 1, 1, P_ALE, 0, "wr_ale");
        pe(c0 + 1, 1, P_DOUT, 32'hABCD, "wr_adr");
        pe(c0 + 1, 1, P_ADRHI, 32'h2, "wr_ahi");
        pe(c0 + 1, 1, P_PIO, 1, "wr_pio_a");
        pe(c0 + 2, 1, P_DOUT, 32'h1234, "wr_hold_d");
        pe(c0 + 2, 1, P_WE, 1, "wr_we_pre");
        pe(c0 + 3, 1, P_WE, 0, "wr_we");
        pe(c0 + 3, 1, P_DOUT, 32'h1234, "wr_dout");
        pe(c0 + 3, 1, P_PIO, 1, "wr_pio");
        pe(c0 + 3, 1, P_ISOUT, 1, "wr_isout");
        pe(c0 + 4, 1, P_WE, 1, "wr_we_post");
        for (int d = 1; d <= 4; d++)
            pe(c0 + d, 1, P_OE, 1, "wr_no_oe");
        ae(1, c0 + 4, 1, 16'h0000);
        at(c0 + 5);
        req_b = '0;

        // Fixed priority: channel 0 wins every transfer
        at(cyc + 3);
        c0 = cyc;
        rw = '0;
        io = '0;
        din = 16'h7777;
        adr = {20'h30003, 20'h20002, 20'h10001};
        req_b = 3'b111;
        for (int t = 0; t < 6; t++) begin
            ae(1, c0 + 4 + 5 * t, 0, 16'h7777);
            pe(c0 + 1 + 5 * t, 1, P_DOUT, 32'h1, "fx_dout");
        end
        at(c0 + 30);
        req_b = '0;

        // WAIT=15 read: sixteen strobe cycles, dtr held until ack
        at(cyc + 3);
        c0 = cyc;
        adr[19:0] = 20'h5A3C4;
        din = 16'hCAFE;
        req_c = 3'b001;
        pe(c0 + 2, 2, P_OE, 1, "lw_oe_pre");
        for (int d = 0; d < 16; d++)
            pe(c0 + 3 + d, 2, P_OE, 0, "lw_oe");
        pe(c0 + 19, 2, P_OE, 1, "lw_oe_post");
        pe(c0 + 18, 2, P_DTR, 0, "lw_dtr_hold");
        ae(2, c0 + 19, 0, 16'hCAFE);
        at(c0 + 20);
        req_c = '0;

        // Reset during the data phase of a write
        at(cyc + 3);
        c0 = cyc;
        rw = 3'b001;
        dtw[15:0] = 16'h5555;
        req_a = 3'b001;
        pe(c0 + 2, 0, P_ISOUT, 1, "rs_pre_isout");
        pe(c0 + 3, 0, P_WE, 1, "rs_we");
        pe(c0 + 3, 0, P_ISOUT, 0, "rs_isout");
        pe(c0 + 3, 0, P_ACK, 0, "rs_ack");
        pe(c0 + 3, 0, P_BUSY, 0, "rs_busy");
        pe(c0 + 4, 0, P_DTR, 0, "rs_dtr");
        at(c0 + 3);
        reset = 1'b1;
        req_a = '0;
        at(c0 + 5);
        reset = 1'b0;
        at(c0 + 7);
        c1 = cyc;
        rw = '0;
        din = 16'hCAFE;
        req_a = 3'b001;
        pe(c1 + 1, 0, P_ALE, 0, "rs_new_ale");
        ae(0, c1 + 5, 0, 16'hCAFE);
        at(c1 + 6);
        req_a = '0;

        at(cyc + 4);
        done = 1'b1;
    end

endmodule
